matrix_addsub_seq: RTL

Sequential element-wise add/subtract engine for the matrix coprocessor. It latches two packed N×N matrices of 8-bit signed elements and streams one element pair per cycle through an 8-bit ripple-carry add stage, with subtraction done as A + ~B + 1. It writes each result back into a packed result register and reports completion and signed overflow. It sits directly upstream of the result writeback path and is the only consumer of the 8-bit adder datapath.

---
 rtl/matrix_addsub_seq_if.sv | 25 ++
 rtl/matrix_addsub_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/matrix_addsub_seq_if.sv
// Handshake and operand/result bundle for matrix_addsub_seq.
// The master drives start/op_sub/operands; the slave (the engine) returns status and results.
interface matrix_addsub_seq_if #(
    parameter int N = 5,
    parameter int W = 8
);
    logic             start;
    logic             op_sub;
    logic [N*N*W-1:0] mat_a;
    logic [N*N*W-1:0] mat_b;
    logic             busy;
    logic             done;
    logic [N*N*W-1:0] result;
    logic             ovf;

    modport master (
        output start, op_sub, mat_a, mat_b,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, op_sub, mat_a, mat_b,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/matrix_addsub_seq.sv
// Sequential element-wise add/subtract of two N x N signed 8-bit matrices, one element per cycle.
// Build option MATRIX_ADDSUB_SAT_EN: saturate overflowing elements instead of wrapping.
module matrix_addsub_seq #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_addsub_seq_if.slave   bus
);
    localparam int NN   = N * N;
    localparam int IDXW = $clog2(NN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic [NN*W-1:0]   r_a;
    logic [NN*W-1:0]   r_b;
    logic              r_sub;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_res [NN];

    logic [W-1:0]      w_a_arr [NN];
    logic [W-1:0]      w_b_arr [NN];
    logic [W-1:0]      w_a_el;
    logic [W-1:0]      w_b_el;
    logic [W-1:0]      w_b_op;
    logic [W-1:0]      w_sum;
    logic [W-1:0]      w_wr;
    logic [W:0]        w_carry;
    logic              w_el_ovf;

    // Unpack latched operands and repack results element by element
    for (genvar gi = 0; gi < NN; gi++) begin : g_elem
        assign w_a_arr[gi]                = r_a[gi*W +: W];
        assign w_b_arr[gi]                = r_b[gi*W +: W];
        assign bus.result[gi*W +: W]      = r_res[gi];
    end

    assign w_a_el = w_a_arr[r_idx];
    assign w_b_el = w_b_arr[r_idx];

    // Subtraction is A + ~B + 1: invert B and feed op_sub in as carry-in
    assign w_b_op     = r_sub ? ~w_b_el : w_b_el;
    assign w_carry[0] = r_sub;
    for (genvar gi = 0; gi < W; gi++) begin : g_rca
        assign w_sum[gi]       = w_a_el[gi] ^ w_b_op[gi] ^ w_carry[gi];
        assign w_carry[gi+1]   = (w_a_el[gi] & w_b_op[gi]) |
                                 (w_carry[gi] & (w_a_el[gi] ^ w_b_op[gi]));
    end

    assign w_el_ovf = w_carry[W-1] ^ w_carry[W];

`ifdef MATRIX_ADDSUB_SAT_EN
    // On overflow both addends share A's sign, so A's sign is the true result's sign
    assign w_wr = w_el_ovf ? (w_a_el[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                           : w_sum;
`else
    assign w_wr = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NN; i++) r_res[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.mat_a;
                        r_b     <= bus.mat_b;
                        r_sub   <= bus.op_sub;
                        r_ovf   <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                        for (int i = 0; i < NN; i++) r_res[i] <= '0;
                    end
                end
                S_RUN: begin
                    r_res[r_idx] <= w_wr;
                    if (w_el_ovf) r_ovf <= 1'b1;
                    if (r_idx == IDXW'(NN - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
endmodule
